mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbiter and sequencer for a single-port unified memory shared by the pipelined core's instruction-fetch stage (IF) and memory stage (D).
- Grants one requester at a time, drives the memory port, counts the fixed memory latency, and routes the response back to the owner.
- Produces stall signals the pipeline uses to freeze the PC/IF-ID registers or the EX-MEM/MEM-WB registers.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
WIDTH, 32, data/address width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range 1..15)
STARVE_MAX, 4, consecutive data grants that IF may lose before IF is forced to win (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request; held stable with if_addr until if_rvalid
if_addr  in  WIDTH  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  WIDTH  fetch data
d_req  in  1  data request; held stable with d_we/d_addr/d_wdata until d_rvalid
d_we  in  1  1 = store, 0 = load
d_addr  in  WIDTH  data address
d_wdata  in  WIDTH  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid / store complete (1-cycle pulse)
d_rdata  out  WIDTH  load data
mem_en  out  1  memory access start (1-cycle pulse)
mem_we  out  1  memory write enable, valid with mem_en
mem_addr  out  WIDTH  memory address, valid with mem_en
mem_wdata  out  WIDTH  memory write data, valid with mem_en
mem_rdata  in  WIDTH  memory read data, valid MEM_LAT cycles after mem_en
stall_if  out  1  freeze fetch side
stall_mem  out  1  freeze memory side

Behaviour:
- **FSM states:** IDLE, BUSY_IF, BUSY_D. Latency counter lat_cnt is 4 bits; starvation counter starve_cnt is 4 bits.
- **Reset:**
  - state = IDLE, lat_cnt = 0, starve_cnt = 0.
  - All 1-bit outputs are 0. if_rdata, d_rdata, mem_addr and mem_wdata are 0.
  - Reset asserted mid-access drops the in-flight access: no rvalid is ever produced for it.
- **IDLE arbitration** (combinational outputs in the same cycle):
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both: grant IF if starve_cnt == STARVE_MAX, else grant D.
- **On grant:**
  - The winner's gnt = 1 and mem_en = 1.
  - mem_addr takes the winner's addr. For D, mem_we = d_we and mem_wdata = d_wdata. For IF, mem_we = 0.
  - Next state is BUSY_IF or BUSY_D, with lat_cnt = 1.
- **BUSY_x:**
  - lat_cnt increments each cycle.
  - When lat_cnt == MEM_LAT: x_rvalid = 1 and x_rdata = mem_rdata (pass-through), and next state is IDLE.
  - D stores also pulse d_rvalid; d_rdata is then don't-care.
  - A new grant is never issued in BUSY, so back-to-back accesses are spaced MEM_LAT+1 cycles apart.
- **Outside their rvalid cycle**, if_rdata and d_rdata hold their last delivered value (registered copy).
- **starve_cnt:**
  - Increments (saturating at STARVE_MAX) on each D grant while if_req = 1.
  - Clears to 0 on an IF grant, or in any cycle with if_req = 0.
- **Stalls:**
  - stall_if = if_req & ~if_rvalid.
  - stall_mem = d_req & ~d_rvalid.
  - Both are combinational.
- **Requester rules:**
  - A requester keeps req high through its rvalid cycle.
  - From the following cycle, req reflects the next request or is 0.
  - Changing addr/we/wdata while req is high and before rvalid is illegal; the bench asserts on it.
- **Sampling point:** a request that arrives while the other port is BUSY waits. It is evaluated in the IDLE cycle after that port's rvalid.

Test Plan:
- **Reset / idle:** reset asserted, then both req = 0 -> all outputs 0 and state stays IDLE for 10 cycles.
- **Single fetch** (MEM_LAT = 2): if_req = 1, if_addr = 0x10 at cycle 0 -> if_gnt and mem_en at cycle 0; if_rvalid at cycle 2 with if_rdata = mem_rdata = 0x00500093; stall_if = 1 at cycles 0–1 and 0 at cycle 2.
- **Simultaneous requests:** load 0x100 and fetch 0x20 both at cycle 0 -> D granted at cycle 0 and d_rvalid at cycle 2; IF granted at cycle 3 and if_rvalid at cycle 5.
- **Store:** d_req = 1, d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF -> mem_we = 1 with matching addr/wdata at the grant cycle; d_rvalid pulses MEM_LAT cycles later.
- **Starvation** (STARVE_MAX = 4): if_req held high while d_req is reasserted after each d_rvalid -> exactly 4 D grants, then an IF grant, then starve_cnt = 0.
- **Reset mid-access:** rst pulsed 1 cycle after an IF grant -> no if_rvalid is produced; after reset a new fetch completes normally with MEM_LAT latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one fixed-latency memory port between the fetch (IF)
// and data (D) requesters; the data port wins unless fetch has been starved.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall_if,
  output logic             stall_mem
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       lat_cnt_q, lat_cnt_d;
  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             d_we_q, d_we_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic grant_if, grant_d, lat_done, if_rv, d_rv;

  // Arbitration only happens in IDLE; a request arriving during BUSY waits.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (d_req && !(if_req && starve_cnt_q == STARVE_LIM)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  assign lat_done = (lat_cnt_q == LAT_LAST);
  assign if_rv    = (state_q == BUSY_IF) && lat_done && !rst;
  assign d_rv     = (state_q == BUSY_D) && lat_done && !rst;

  always_comb begin
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    mem_en    = grant_if | grant_d;
    mem_we    = grant_d & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_if) begin
      mem_addr = if_addr;
    end
  end

  // Read data passes straight through on the rvalid cycle and is held afterwards;
  // a store completion leaves the held load data untouched.
  assign if_rvalid = if_rv;
  assign d_rvalid  = d_rv;
  assign if_rdata  = if_rv ? mem_rdata : if_rdata_q;
  assign d_rdata   = (d_rv && !d_we_q) ? mem_rdata : d_rdata_q;

  assign stall_if  = if_req & ~if_rv & ~rst;
  assign stall_mem = d_req & ~d_rv & ~rst;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    d_we_d     = d_we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d   = BUSY_D;
          lat_cnt_d = 4'd1;
          d_we_d    = d_we;
        end else if (grant_if) begin
          state_d   = BUSY_IF;
          lat_cnt_d = 4'd1;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (lat_done) begin
          state_d   = IDLE;
          lat_cnt_d = 4'd0;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        lat_cnt_d = 4'd0;
      end
    endcase
    if (if_rv) if_rdata_d = mem_rdata;
    if (d_rv && !d_we_q) d_rdata_d = mem_rdata;
  end

  // Starvation counts D wins while fetch is waiting; any idle fetch cycle clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req) begin
      starve_cnt_d = 4'd0;
    end else if (grant_d) begin
      if (starve_cnt_q != STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;
    end else if (grant_if) begin
      starve_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      d_we_q       <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      d_we_q       <= d_we_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle
// plus hand-computed timing/data expectations for each scenario.
module tb_mem_port_arbiter;
  localparam int W          = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic         if_gnt, if_rvalid;
  logic [W-1:0] if_rdata;
  logic         d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] d_addr = '0, d_wdata = '0;
  logic         d_gnt, d_rvalid;
  logic [W-1:0] d_rdata;
  logic         mem_en, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         stall_if, stall_mem;

  mem_port_arbiter #(.WIDTH(W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [W-1:0] addr; logic [W-1:0] wdata;} dreq_t;
  logic [W-1:0] if_q[$];
  dreq_t        d_q[$];

  int nvec = 0, nmis = 0, cyc = 0, t0 = 0;
  logic rst_cmd = 1'b0;
  logic if_done_last = 1'b0, d_done_last = 1'b0;

  // Environment memory (driven by the DUT's port) and the model's own memory image.
  logic [W-1:0] env_mem [256];
  logic [W-1:0] mdl_mem [256];
  logic         pv [16];
  logic [W-1:0] pa [16];

  // Transaction-level model state.
  int           m_owner = 0;  // 0 none, 1 fetch, 2 data
  int           m_done = 0;
  logic [W-1:0] m_addr = '0;
  logic         m_we = 1'b0;
  int           m_starve = 0;
  logic [W-1:0] m_if_hold = '0, m_d_hold = '0;
  logic         m_d_known = 1'b1;

  // Scenario records.
  int           r_if_gnt, r_if_rv, r_d_gnt, r_d_rv, r_dg_before, r_if_rv_cnt;
  logic [W-1:0] r_if_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
  logic         r_mem_we, any_out;
  logic         stall_hist [16];

  logic         prev_if_req = 1'b0, prev_if_rv = 1'b0, prev_d_req = 1'b0, prev_d_rv = 1'b0;
  logic [W-1:0] prev_if_addr = '0, prev_d_addr = '0, prev_d_wdata = '0;
  logic         prev_d_we = 1'b0;

  task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic begin_scen();
    t0 = cyc;
    r_if_gnt = -1; r_if_rv = -1; r_d_gnt = -1; r_d_rv = -1;
    r_dg_before = 0; r_if_rv_cnt = 0;
    r_if_rdata = '0; r_d_rdata = '0; r_mem_addr = '0; r_mem_wdata = '0;
    r_mem_we = 1'b0; any_out = 1'b0;
    for (int i = 0; i < 16; i++) stall_hist[i] = 1'b0;
  endtask

  task automatic model_check();
    logic         e_if_rv, e_d_rv, e_gi, e_gd;
    logic [W-1:0] data, e_if_rd, e_d_rd;
    e_if_rv = 1'b0; e_d_rv = 1'b0; e_gi = 1'b0; e_gd = 1'b0;
    if (rst) begin
      m_owner = 0; m_starve = 0; m_if_hold = '0; m_d_hold = '0; m_d_known = 1'b1;
    end else begin
      e_if_rv = (m_owner == 1) && (cyc == m_done);
      e_d_rv  = (m_owner == 2) && (cyc == m_done);
      if (m_owner == 0) begin
        if (d_req && (!if_req || m_starve != STARVE_MAX)) e_gd = 1'b1;
        else if (if_req) e_gi = 1'b1;
      end
    end
    data    = mdl_mem[m_addr[9:2]];
    e_if_rd = e_if_rv ? data : m_if_hold;
    e_d_rd  = (e_d_rv && !m_we) ? data : m_d_hold;
    cmp("if_gnt", 32'(if_gnt), 32'(e_gi));
    cmp("d_gnt", 32'(d_gnt), 32'(e_gd));
    cmp("mem_en", 32'(mem_en), 32'(e_gi | e_gd));
    if (e_gi | e_gd) begin
      cmp("mem_we", 32'(mem_we), 32'(e_gd & d_we));
      cmp("mem_addr", mem_addr, e_gd ? d_addr : if_addr);
    end
    if (e_gd) cmp("mem_wdata", mem_wdata, d_wdata);
    cmp("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
    cmp("d_rvalid", 32'(d_rvalid), 32'(e_d_rv));
    cmp("if_rdata", if_rdata, e_if_rd);
    if (m_d_known && !(e_d_rv && m_we)) cmp("d_rdata", d_rdata, e_d_rd);
    cmp("stall_if", 32'(stall_if), 32'(!rst & if_req & ~e_if_rv));
    cmp("stall_mem", 32'(stall_mem), 32'(!rst & d_req & ~e_d_rv));
    if (!rst) begin
      if (e_if_rv) begin m_if_hold = data; m_owner = 0; end
      if (e_d_rv) begin
        if (m_we) m_d_known = 1'b0;
        else begin m_d_hold = data; m_d_known = 1'b1; end
        m_owner = 0;
      end
      if (e_gd || e_gi) begin
        m_owner = e_gd ? 2 : 1;
        m_done  = cyc + MEM_LAT;
        m_addr  = e_gd ? d_addr : if_addr;
        m_we    = e_gd & d_we;
        if (m_we) mdl_mem[d_addr[9:2]] = d_wdata;
      end
      if (!if_req) m_starve = 0;
      else if (e_gd) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else if (e_gi) m_starve = 0;
    end
  endtask

  task automatic tick();
    dreq_t dr;
    @(negedge clk);
    rst = rst_cmd;
    if (rst) begin
      if_req = 1'b0; d_req = 1'b0; if_done_last = 1'b0; d_done_last = 1'b0;
    end else begin
      if (if_done_last) if_req = 1'b0;
      if (!if_req && if_q.size() > 0) begin if_req = 1'b1; if_addr = if_q.pop_front(); end
      if (d_done_last) d_req = 1'b0;
      if (!d_req && d_q.size() > 0) begin
        dr = d_q.pop_front();
        d_req = 1'b1; d_we = dr.we; d_addr = dr.addr; d_wdata = dr.wdata;
      end
    end
    mem_rdata = pv[MEM_LAT-1] ? env_mem[pa[MEM_LAT-1][9:2]] : (32'hBAD0_0000 ^ 32'(cyc));
    #1;
    if (prev_if_req && !prev_if_rv && if_req)
      assert (if_addr == prev_if_addr) else $error("illegal stimulus: if_addr changed mid-request");
    if (prev_d_req && !prev_d_rv && d_req)
      assert (d_addr == prev_d_addr && d_we == prev_d_we && d_wdata == prev_d_wdata)
        else $error("illegal stimulus: data request changed mid-request");
    model_check();
    if (if_gnt && r_if_gnt < 0) r_if_gnt = cyc - t0;
    if (d_gnt && r_if_gnt < 0) r_dg_before++;
    if (d_gnt && r_d_gnt < 0) begin
      r_d_gnt = cyc - t0; r_mem_we = mem_we; r_mem_addr = mem_addr; r_mem_wdata = mem_wdata;
    end
    if (if_rvalid) begin
      r_if_rv_cnt++; r_if_rdata = if_rdata;
      if (r_if_rv < 0) r_if_rv = cyc - t0;
    end
    if (d_rvalid) begin
      if (r_d_rv < 0) r_d_rv = cyc - t0;
      if (!d_we) r_d_rdata = d_rdata;
    end
    if (cyc - t0 < 16) stall_hist[cyc - t0] = stall_if;
    any_out = any_out | if_gnt | if_rvalid | d_gnt | d_rvalid | mem_en | mem_we | stall_if
              | stall_mem | (|mem_addr) | (|mem_wdata) | (|if_rdata) | (|d_rdata);
    if_done_last = if_rvalid; d_done_last = d_rvalid;
    prev_if_req = if_req; prev_if_rv = if_rvalid; prev_if_addr = if_addr;
    prev_d_req = d_req; prev_d_rv = d_rvalid; prev_d_addr = d_addr;
    prev_d_we = d_we; prev_d_wdata = d_wdata;
    for (int i = MEM_LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
    pv[0] = mem_en; pa[0] = mem_addr;
    if (mem_en && mem_we) env_mem[mem_addr[9:2]] = mem_wdata;
    cyc++;
  endtask

  task automatic run_quiet(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((if_q.size() > 0 || d_q.size() > 0 || if_req || d_req) && n < budget);
    if (n >= budget) begin
      nvec++; nmis++;
      $display("FAIL timeout cyc=%0d got=busy expected=quiet within %0d cycles", cyc, budget);
    end
  endtask

  task automatic push_d(input logic we, input logic [W-1:0] a, input logic [W-1:0] wd);
    dreq_t r;
    r.we = we; r.addr = a; r.wdata = wd;
    d_q.push_back(r);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h1000_0000 + 32'(i);
      mdl_mem[i] = 32'h1000_0000 + 32'(i);
    end
    env_mem[4] = 32'h0050_0093;
    mdl_mem[4] = 32'h0050_0093;
    for (int i = 0; i < 16; i++) begin pv[i] = 1'b0; pa[i] = '0; end

    // Reset and idle.
    begin_scen();
    rst_cmd = 1'b1;
    tick(); tick();
    cmp("rst_mem_en", 32'(mem_en), 0);
    cmp("rst_if_rdata", if_rdata, 0);
    cmp("rst_d_rdata", d_rdata, 0);
    cmp("rst_mem_addr", mem_addr, 0);
    rst_cmd = 1'b0;
    begin_scen();
    for (int i = 0; i < 10; i++) tick();
    cmp("idle_any_output", 32'(any_out), 0);

    // Single fetch.
    begin_scen();
    if_q.push_back(32'h10);
    run_quiet(20);
    cmp("fetch_gnt_cycle", r_if_gnt, 0);
    cmp("fetch_rvalid_cycle", r_if_rv, 2);
    cmp("fetch_rdata", r_if_rdata, 32'h0050_0093);
    cmp("fetch_stall_c0", 32'(stall_hist[0]), 1);
    cmp("fetch_stall_c1", 32'(stall_hist[1]), 1);
    cmp("fetch_stall_c2", 32'(stall_hist[2]), 0);

    // Simultaneous load and fetch: data wins first.
    begin_scen();
    push_d(1'b0, 32'h100, 32'h0);
    if_q.push_back(32'h20);
    run_quiet(30);
    cmp("simul_d_gnt", r_d_gnt, 0);
    cmp("simul_d_rvalid", r_d_rv, 2);
    cmp("simul_if_gnt", r_if_gnt, 3);
    cmp("simul_if_rvalid", r_if_rv, 5);
    cmp("simul_d_rdata", r_d_rdata, 32'h1000_0040);
    cmp("simul_if_rdata", r_if_rdata, 32'h1000_0008);

    // Store followed by a load of the same word.
    begin_scen();
    push_d(1'b1, 32'h40, 32'hDEAD_BEEF);
    push_d(1'b0, 32'h40, 32'h0);
    run_quiet(30);
    cmp("store_gnt", r_d_gnt, 0);
    cmp("store_mem_we", 32'(r_mem_we), 1);
    cmp("store_mem_addr", r_mem_addr, 32'h40);
    cmp("store_mem_wdata", r_mem_wdata, 32'hDEAD_BEEF);
    cmp("store_rvalid", r_d_rv, 2);
    cmp("store_readback", r_d_rdata, 32'hDEAD_BEEF);

    // Starvation: fetch waits behind exactly STARVE_MAX data grants.
    begin_scen();
    if_q.push_back(32'h24);
    for (int i = 0; i < 5; i++) push_d(1'b0, 32'h80 + 32'(4 * i), 32'h0);
    run_quiet(60);
    cmp("starve_d_grants_before_if", r_dg_before, 4);
    cmp("starve_if_gnt", r_if_gnt, 12);
    cmp("starve_if_rdata", r_if_rdata, 32'h1000_0009);

    // Reset one cycle after a fetch grant drops the access.
    begin_scen();
    if_q.push_back(32'h10);
    tick();
    rst_cmd = 1'b1;
    tick();
    rst_cmd = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    cmp("rstmid_gnt", r_if_gnt, 0);
    cmp("rstmid_no_rvalid", r_if_rv_cnt, 0);
    begin_scen();
    if_q.push_back(32'h14);
    run_quiet(20);
    cmp("rstmid_refetch_gnt", r_if_gnt, 0);
    cmp("rstmid_refetch_rvalid", r_if_rv, 2);
    cmp("rstmid_refetch_rdata", r_if_rdata, 32'h1000_0005);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "bench time limit reached");
  end
endmodule
